config_chain_loader: RTL
========================

# config_chain_loader

Serial configuration loader for the DSP slice configuration chain. It accepts a configuration image as a stream of parallel words over a valid/ready handshake, then shifts the image bit-serially into the slice's daisy-chained configuration registers using `configuration_input` and `configuration_enable`. It sits directly upstream of the operation manager, whose chain is the first segment it drives. It optionally captures the previous chain contents returned on the chain tail.

## Interface
- `CHAIN_LEN`, default 18: total configuration bits in the driven chain; must be ≥ 1.
- `WORD_W`, default 32: width of the input word.
- `NUM_WORDS`, derived as ceil(CHAIN_LEN/WORD_W): not overridable.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cfg_start`  in  1  begin a load; sampled only in IDLE.
- `cfg_abort`  in  1  abandon a load in progress.
- `cfg_word_valid`  in  1  word available.
- `cfg_word_ready`  out  1  loader accepts a word.
- `cfg_word_data`  in  WORD_W  image word.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse when the shift completes.
- `configuration_enable`  out  1  shift enable to the chain.
- `configuration_input`  out  1  serial data to the chain head.
- `configuration_output`  in  1  serial data returned from the chain tail.
- `readback_data`  out  CHAIN_LEN  previous chain contents.
- `readback_valid`  out  1  pulses together with `done`.

## Operation
- FSM states: IDLE, COLLECT, SHIFT, DONE.
  - IDLE → COLLECT when `cfg_start` = 1.
  - COLLECT → SHIFT on the cycle after the NUM_WORDS-th handshake.
  - SHIFT → DONE after CHAIN_LEN enabled cycles.
  - DONE → IDLE unconditionally.
- Image assembly:
  - The k-th accepted word (k = 0 first) supplies image bits [k·WORD_W +: WORD_W].
  - Bits at or above CHAIN_LEN in the last word are discarded.
  - A handshake is `cfg_word_valid & cfg_word_ready`.
  - `cfg_word_ready` = 1 only in COLLECT.
- Shift order:
  - Image bit CHAIN_LEN-1 is shifted first and bit 0 last.
  - After the load, image bit 0 sits in the chain head and bit CHAIN_LEN-1 sits in the tail.
- Readback: on each enabled edge i (i = 0..CHAIN_LEN-1), capture `configuration_output` into `readback_data[CHAIN_LEN-1-i]`.
- Abort: `cfg_abort` in any non-IDLE state forces IDLE on the next edge.
  - `configuration_enable` drops to 0 from that edge.
  - No `done`, no `readback_valid`.
  - The chain is left partially shifted.
  - Abort wins over a simultaneous handshake or over the final shift.
- `cfg_start` outside IDLE is ignored. In IDLE, `cfg_start` and `cfg_abort` asserted together → stay IDLE.
- Bit counter: width $clog2(CHAIN_LEN+1); never wraps and never exceeds CHAIN_LEN.

## Timing
- Reset values:
  - State IDLE.
  - `cfg_word_ready`, `busy`, `done`, `configuration_enable`, `configuration_input`, `readback_valid` = 0.
  - `readback_data` = 0.
  - Word and bit counters = 0.
- Reset mid-load: same result as abort, but the image and readback registers are also cleared.
- `configuration_enable` and `configuration_input` are flop outputs.
  - Enable is high for exactly CHAIN_LEN consecutive cycles.
  - The first enabled cycle is the cycle after the state enters SHIFT.
- `done` and `readback_valid` are high for the single DONE cycle, which is the cycle after the last enabled cycle.
- Latency from the last word handshake to `done`: CHAIN_LEN + 2 cycles.
- `cfg_word_valid` may be held high continuously, giving one word per cycle in COLLECT.

## Configuration
- Macro: `CFG_READBACK_EN`.
- Defined: tail capture logic and `readback_data`/`readback_valid` behave as above.
- Undefined:
  - The capture register is not built.
  - `readback_data` is tied to 0 and `readback_valid` is tied to 0.
  - `configuration_output` is unused.
  - Ports remain present.

## Structure
- Shared package `apir_cfg_pkg` holds:
  - The FSM state enum `cfg_load_state_t`.
  - The default chain length constant `OPMGR_CHAIN_LEN` = 18.
- One sub-module: `cfg_shift_serializer`.
  - Holds the CHAIN_LEN image register, the bit counter and the output flops.
  - Driven by a load strobe and a go strobe from the FSM.

## Test plan
- CHAIN_LEN=18, WORD_W=32: load 0x0002ABCD into an 18-bit chain model → `done` exactly 20 cycles after the handshake; model holds 0x2ABCD; enable high for exactly 18 cycles.
- Two back-to-back loads, 0x3FFFF then 0x00000, with `CFG_READBACK_EN` defined → second `readback_data` = 0x3FFFF; model = 0.
- WORD_W=8: words 0xCD, 0xAB, 0xFE → image 0x2ABCD; the upper 6 bits of 0xFE are ignored; `cfg_word_ready` stalls correctly while `cfg_word_valid` toggles.
- `cfg_abort` after 7 enabled cycles → `configuration_enable` low the next cycle; no `done`; `busy` = 0; a new `cfg_start` completes a full load.
- `rst_n` = 0 during COLLECT with 1 of 3 words accepted → all outputs 0 next cycle; a subsequent load needs all 3 words again.
- `cfg_start` pulsed during SHIFT → ignored; exactly one `done`.

Source files
------------

// File: rtl/apir_cfg_pkg.sv
// Shared definitions for the DSP slice configuration chain loaders:
// the loader FSM state type, the operation manager chain length and a
// small integer helper used to size word counters.
package apir_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } cfg_load_state_t;

  localparam int OPMGR_CHAIN_LEN = 18;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/cfg_shift_serializer.sv
// Image register, bit counter and chain-facing output flops of the
// configuration loader. Words are written into the image under the load
// strobe; while go is held the image is presented MSB first, one bit per
// cycle, with a registered enable. Optional tail capture is built only
// when CFG_READBACK_EN is defined.
module cfg_shift_serializer
  import apir_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = OPMGR_CHAIN_LEN,
  parameter int WORD_W    = 32,
  parameter int WCNT_W    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 go,
  input  logic [WCNT_W-1:0]    word_idx,
  input  logic [WORD_W-1:0]    word_data,
  input  logic                 configuration_output,
  output logic                 configuration_enable,
  output logic                 configuration_input,
  output logic                 shift_last,
  output logic [CHAIN_LEN-1:0] readback_data
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  logic [CHAIN_LEN-1:0] image;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 tap;

  assign shift_last = (bit_cnt == CNT_W'(CHAIN_LEN));

  // Write the bits of the image that belong to the current word; bits of
  // the word that land at or above CHAIN_LEN simply have no destination.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      image <= '0;
    end else if (load) begin
      for (int b = 0; b < CHAIN_LEN; b++) begin
        if (word_idx == WCNT_W'(b / WORD_W)) begin
          image[b] <= word_data[b % WORD_W];
        end
      end
    end
  end

  // Select the image bit for the next shift: count 0 picks the MSB, the
  // final count picks bit 0.
  always_comb begin
    tap = 1'b0;
    for (int b = 0; b < CHAIN_LEN; b++) begin
      if (bit_cnt == CNT_W'(CHAIN_LEN - 1 - b)) begin
        tap = image[b];
      end
    end
  end

  // Drive the chain: one enabled bit per cycle until CHAIN_LEN bits are
  // out, then hold the count saturated until go drops, which clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt              <= '0;
      configuration_enable <= 1'b0;
      configuration_input  <= 1'b0;
    end else if (go && !shift_last) begin
      bit_cnt              <= bit_cnt + 1'b1;
      configuration_enable <= 1'b1;
      configuration_input  <= tap;
    end else if (go) begin
      configuration_enable <= 1'b0;
      configuration_input  <= 1'b0;
    end else begin
      bit_cnt              <= '0;
      configuration_enable <= 1'b0;
      configuration_input  <= 1'b0;
    end
  end

`ifdef CFG_READBACK_EN
  // Capture the old chain contents as they fall out of the tail; the k-th
  // enabled edge (count k+1) fills readback bit CHAIN_LEN-1-k.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      readback_data <= '0;
    end else if (go && configuration_enable) begin
      for (int b = 0; b < CHAIN_LEN; b++) begin
        if (bit_cnt == CNT_W'(CHAIN_LEN - b)) begin
          readback_data[b] <= configuration_output;
        end
      end
    end
  end
`else
  logic unused_tail;

  assign unused_tail   = configuration_output;
  assign readback_data = '0;
`endif

endmodule

// File: rtl/config_chain_loader.sv
// Serial configuration loader for the DSP slice configuration chain.
// Collects NUM_WORDS image words over a valid/ready handshake, then shifts
// the image MSB first into the daisy chain and pulses done. Defining
// CFG_READBACK_EN adds capture of the previous chain contents from the
// chain tail; otherwise readback_data and readback_valid stay at 0.
module config_chain_loader
  import apir_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = OPMGR_CHAIN_LEN,
  parameter int WORD_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic                 cfg_word_valid,
  output logic                 cfg_word_ready,
  input  logic [WORD_W-1:0]    cfg_word_data,
  output logic                 busy,
  output logic                 done,
  output logic                 configuration_enable,
  output logic                 configuration_input,
  input  logic                 configuration_output,
  output logic [CHAIN_LEN-1:0] readback_data,
  output logic                 readback_valid
);

  localparam int NUM_WORDS = ceil_div(CHAIN_LEN, WORD_W);
  localparam int WCNT_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  cfg_load_state_t   state;
  cfg_load_state_t   state_next;
  logic [WCNT_W-1:0] word_cnt;
  logic              handshake;
  logic              last_word;
  logic              shift_last;
  logic              load;
  logic              go;

  assign cfg_word_ready = (state == COLLECT);
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign handshake      = cfg_word_valid & cfg_word_ready;
  assign last_word      = (word_cnt == WCNT_W'(NUM_WORDS - 1));
  assign load           = handshake & ~cfg_abort;
  assign go             = (state == SHIFT) & ~cfg_abort;

`ifdef CFG_READBACK_EN
  assign readback_valid = (state == DONE);
`else
  assign readback_valid = 1'b0;
`endif

  // Loader state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort takes priority over every other exit.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cfg_start && !cfg_abort) begin
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (cfg_abort) begin
          state_next = IDLE;
        end else if (handshake && last_word) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cfg_abort) begin
          state_next = IDLE;
        end else if (shift_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Word counter: indexes the image slice of the next accepted word and is
  // cleared whenever the loader is not collecting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (state != COLLECT || cfg_abort) begin
      word_cnt <= '0;
    end else if (handshake) begin
      word_cnt <= last_word ? '0 : word_cnt + 1'b1;
    end
  end

  cfg_shift_serializer #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W),
    .WCNT_W    (WCNT_W)
  ) u_serializer (
    .clk                  (clk),
    .rst_n                (rst_n),
    .load                 (load),
    .go                   (go),
    .word_idx             (word_cnt),
    .word_data            (cfg_word_data),
    .configuration_output (configuration_output),
    .configuration_enable (configuration_enable),
    .configuration_input  (configuration_input),
    .shift_last           (shift_last),
    .readback_data        (readback_data)
  );

endmodule
